// File: rtl/trashbin_mem_port_if.sv
// Memory-bus bundle between the TrashbinCore (master) and trashbin_mem_port (slave).
// ByteEnable exists only when TRASHBIN_MEM_BYTE_LANES_EN is defined.
interface trashbin_mem_port_if;
  logic [31:0] AddressBus;
  logic [31:0] DataWriteBus;
  logic        ReadAssert;
  logic        WriteAssert;
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
  logic [3:0]  ByteEnable;
`endif
  logic [31:0] DataReadBus;
  logic        ReadOK;
  logic        WriteOK;
  logic        BusError;
  logic        Busy;

`ifdef TRASHBIN_MEM_BYTE_LANES_EN
  modport master (
    output AddressBus, DataWriteBus, ReadAssert, WriteAssert, ByteEnable,
    input  DataReadBus, ReadOK, WriteOK, BusError, Busy
  );
  modport slave (
    input  AddressBus, DataWriteBus, ReadAssert, WriteAssert, ByteEnable,
    output DataReadBus, ReadOK, WriteOK, BusError, Busy
  );
`else
  modport master (
    output AddressBus, DataWriteBus, ReadAssert, WriteAssert,
    input  DataReadBus, ReadOK, WriteOK, BusError, Busy
  );
  modport slave (
    input  AddressBus, DataWriteBus, ReadAssert, WriteAssert,
    output DataReadBus, ReadOK, WriteOK, BusError, Busy
  );
`endif
endinterface

// File: rtl/trashbin_mem_port.sv
// Word-RAM responder for the TrashbinCore memory bus with programmable wait states.
// Optional per-byte write lanes are enabled by defining TRASHBIN_MEM_BYTE_LANES_EN.
module trashbin_mem_port #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic                 CoreClock,
  input logic                 Reset,
  trashbin_mem_port_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_rd_q, req_rd_d;
  logic        req_wr_q, req_wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        read_ok_q, read_ok_d;
  logic        write_ok_q, write_ok_d;
  logic        bus_err_q, bus_err_d;
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
  logic [3:0]  be_q, be_d;
`endif

  logic [31:0] idx_full;
  logic [AW-1:0] ram_idx;
  logic        in_range;
  logic        acc_err;
  logic        done;
  logic        ram_we;

  // Offset wraps on underflow, so addresses below BASE_ADDR land out of range.
  assign idx_full = (addr_q - BASE_ADDR) >> 2;
  assign ram_idx  = idx_full[AW-1:0];
  assign in_range = (idx_full >> AW) == 32'd0;
  assign acc_err  = (req_rd_q & req_wr_q) | (addr_q[1:0] != 2'b00) | ~in_range;
  assign done     = (state_q == StWait) && (cnt_q == 4'd0);
  assign ram_we   = done && req_wr_q && !req_rd_q && !acc_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_rd_d   = req_rd_q;
    req_wr_d   = req_wr_q;
    rdata_d    = rdata_q;
    read_ok_d  = 1'b0;
    write_ok_d = 1'b0;
    bus_err_d  = 1'b0;
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
    be_d       = be_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.ReadAssert || bus.WriteAssert) begin
          addr_d   = bus.AddressBus;
          wdata_d  = bus.DataWriteBus;
          req_rd_d = bus.ReadAssert;
          req_wr_d = bus.WriteAssert;
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
          be_d     = bus.ByteEnable;
`endif
          cnt_d    = WaitCnt;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d    = StAck;
          // Both requests at once complete as an erroring read.
          read_ok_d  = req_rd_q;
          write_ok_d = req_wr_q & ~req_rd_q;
          bus_err_d  = acc_err;
          if (req_rd_q) begin
            rdata_d = acc_err ? 32'h0 : mem[ram_idx];
          end
        end
      end
      StAck: begin
        state_d = StHold;
      end
      StHold: begin
        if (!bus.ReadAssert && !bus.WriteAssert) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CoreClock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      req_rd_q   <= 1'b0;
      req_wr_q   <= 1'b0;
      rdata_q    <= 32'h0;
      read_ok_q  <= 1'b0;
      write_ok_q <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
      be_q       <= 4'h0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_rd_q   <= req_rd_d;
      req_wr_q   <= req_wr_d;
      rdata_q    <= rdata_d;
      read_ok_q  <= read_ok_d;
      write_ok_q <= write_ok_d;
      bus_err_q  <= bus_err_d;
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
      be_q       <= be_d;
`endif
    end
  end

  // RAM is deliberately not reset; reset drops state to IDLE so no write can follow it.
  always_ff @(posedge CoreClock) begin
    if (ram_we) begin
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
`else
      mem[ram_idx] <= wdata_q;
`endif
    end
  end

  assign bus.DataReadBus = rdata_q;
  assign bus.ReadOK      = read_ok_q;
  assign bus.WriteOK     = write_ok_q;
  assign bus.BusError    = bus_err_q;
  assign bus.Busy        = (state_q != StIdle);

endmodule

// File: tb/tb_trashbin_mem_port.sv
// Scoreboard bench for trashbin_mem_port: directed transactions push expected acks,
// a negedge monitor pops and checks them (including exact ack cycle).
module tb_trashbin_mem_port;

  localparam int unsigned W = 2;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] last_rd = 32'h0;

  exp_t  exp_q[$];
  string name_q[$];

  trashbin_mem_port_if bus();

  trashbin_mem_port #(
    .DEPTH_WORDS (1024),
    .WAIT_STATES (W),
    .BASE_ADDR   (32'h0)
  ) dut (
    .CoreClock (clk),
    .Reset     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every acknowledge must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.ReadOK || bus.WriteOK || bus.BusError) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ack: rok=%b wok=%b err=%b at cycle %0d, required no ack",
                 bus.ReadOK, bus.WriteOK, bus.BusError, cyc);
      end else begin
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus.ReadOK !== e.rd || bus.WriteOK !== e.wr || bus.BusError !== e.err ||
            (e.chk_rd && bus.DataReadBus !== e.rdata) || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL %s: rok=%b wok=%b err=%b rdata=%h cyc=%0d, required rok=%b wok=%b err=%b rdata=%h cyc=%0d",
                   n, bus.ReadOK, bus.WriteOK, bus.BusError, bus.DataReadBus, cyc,
                   e.rd, e.wr, e.err, e.rdata, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic txn(input string name, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be, input bit err,
                     input logic [31:0] exp_rd, input int hold);
    exp_t e;
    bit   seen;
    @(negedge clk);
    bus.AddressBus   = addr;
    bus.DataWriteBus = data;
    bus.ReadAssert   = rd;
    bus.WriteAssert  = wr;
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
    bus.ByteEnable   = be;
`else
    if (be != 4'hF) $display("note: byte enables ignored in this build");
`endif
    e.rd     = rd;
    e.wr     = wr & ~rd;
    e.err    = err;
    e.chk_rd = !(rd && wr);
    if (rd) begin
      e.rdata = err ? 32'h0 : exp_rd;
      last_rd = e.rdata;
    end else begin
      e.rdata = last_rd;
    end
    e.cyc = cyc + int'(W) + 2;
    exp_q.push_back(e);
    name_q.push_back(name);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ReadOK || bus.WriteOK) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no ack within 40 cycles, required one ack", name);
    end
    repeat (hold) @(negedge clk);
    bus.ReadAssert  = 1'b0;
    bus.WriteAssert = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.AddressBus   = 32'h0;
    bus.DataWriteBus = 32'h0;
    bus.ReadAssert   = 1'b0;
    bus.WriteAssert  = 1'b0;
`ifdef TRASHBIN_MEM_BYTE_LANES_EN
    bus.ByteEnable   = 4'hF;
`endif
    repeat (2) @(negedge clk);
    check("reset_rdata", bus.DataReadBus, 32'h0);
    check("reset_acks", {29'h0, bus.ReadOK, bus.WriteOK, bus.BusError}, 32'h0);
    check("reset_busy", {31'h0, bus.Busy}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'h0, bus.Busy}, 32'h0);

    txn("wr_0c",  1'b0, 1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 0);
    txn("rd_0c",  1'b1, 1'b0, 32'h0C, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 0);
    repeat (3) @(negedge clk);
    check("rdata_held", bus.DataReadBus, 32'hDEADBEEF);

    txn("wr_10_hold", 1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0, 32'h0, 5);
    check("rdata_after_write", bus.DataReadBus, 32'hDEADBEEF);
    txn("rd_10_hold", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h12345678, 5);

    txn("rd_misaligned", 1'b1, 1'b0, 32'h02,   32'h0,        4'hF, 1'b1, 32'h0, 0);
    txn("wr_oor",        1'b0, 1'b1, 32'h1000, 32'hBAD0BAD0, 4'hF, 1'b1, 32'h0, 0);
    txn("rd_0c_again",   1'b1, 1'b0, 32'h0C,   32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 0);
    txn("wr_top",        1'b0, 1'b1, 32'hFFC,  32'h0F0F1234, 4'hF, 1'b0, 32'h0, 0);
    txn("rd_top",        1'b1, 1'b0, 32'hFFC,  32'h0,        4'hF, 1'b0, 32'h0F0F1234, 0);
    txn("rd_oor_top",    1'b1, 1'b0, 32'h1000, 32'h0,        4'hF, 1'b1, 32'h0, 0);

    // Reset while a write to 0x20 is still waiting: no ack, RAM keeps old word.
    txn("wr_20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 0);
    @(negedge clk);
    bus.AddressBus   = 32'h20;
    bus.DataWriteBus = 32'h55555555;
    bus.WriteAssert  = 1'b1;
    @(negedge clk);
    check("busy_in_wait", {31'h0, bus.Busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_rdata", bus.DataReadBus, 32'h0);
    check("midrst_busy", {31'h0, bus.Busy}, 32'h0);
    check("midrst_acks", {29'h0, bus.ReadOK, bus.WriteOK, bus.BusError}, 32'h0);
    @(negedge clk);
    bus.WriteAssert = 1'b0;
    rst = 1'b0;
    last_rd = 32'h0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", {31'h0, bus.Busy}, 32'h0);
    txn("rd_20_after_rst", 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 0);

`ifdef TRASHBIN_MEM_BYTE_LANES_EN
    txn("wr_04_full",  1'b0, 1'b1, 32'h04, 32'hAABBCCDD, 4'hF,    1'b0, 32'h0, 0);
    txn("wr_04_lanes", 1'b0, 1'b1, 32'h04, 32'h11223344, 4'b0101, 1'b0, 32'h0, 0);
    txn("rd_04_lanes", 1'b1, 1'b0, 32'h04, 32'h0,        4'hF,    1'b0, 32'hAA22CC44, 0);
    txn("wr_04_none",  1'b0, 1'b1, 32'h04, 32'h99999999, 4'b0000, 1'b0, 32'h0, 0);
    txn("rd_04_none",  1'b1, 1'b0, 32'h04, 32'h0,        4'hF,    1'b0, 32'hAA22CC44, 0);
`endif

    txn("both_asserts", 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 0);
    txn("rd_10_unchanged", 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h12345678, 0);

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_acks: %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
